// File: rtl/bcd_digit_packer_if.sv
// Digit-stream in / packed-word out bundle for bcd_digit_packer.
// din_* and word_* each follow valid/ready: a transfer happens on the rising edge where both are 1.
interface bcd_digit_packer_if #(
  parameter int N = 4
);
  localparam int CW = $clog2(N + 1);

  logic [3:0]     din;
  logic           din_valid;
  logic           din_last;
  logic           din_ready;
  logic [4*N-1:0] word;
  logic [CW-1:0]  word_len;
  logic           word_err;
  logic           word_valid;
  logic           word_ready;

  modport slave (
    input  din, din_valid, din_last, word_ready,
    output din_ready, word, word_len, word_err, word_valid
  );

  modport master (
    output din, din_valid, din_last, word_ready,
    input  din_ready, word, word_len, word_err, word_valid
  );
endinterface

// File: rtl/bcd_digit_packer.sv
// Packs a serial MSD-first BCD digit stream into a right-aligned 4N-bit word for the divisibility checker.
// Optional macro BCD_DIGIT_CHECK_EN builds the digit > 9 error flag; otherwise word_err is tied to 0.
module bcd_digit_packer #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_digit_packer_if.slave  bus,
  output logic               o_dbg_state
);
  localparam int W  = 4 * N;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_sr;
  logic [W-1:0]  r_word;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_len;
  logic          r_err;
  logic          r_werr;

  logic          w_accept;
  logic          w_final;
  logic          w_release;
  logic          w_bad;
  logic [W-1:0]  w_sr_next;

  // Ready depends only on registered state so no combinational path runs from din_valid/word_ready.
  assign bus.din_ready = !rst && (r_state == COLLECT);
  assign w_accept      = bus.din_valid && bus.din_ready;
  assign w_sr_next     = {r_sr[W-5:0], bus.din};
  assign w_final       = w_accept && (bus.din_last || (r_cnt == CW'(N - 1)));
  assign w_release     = (r_state == HOLD) && bus.word_ready;

`ifdef BCD_DIGIT_CHECK_EN
  assign w_bad = (bus.din > 4'd9);
`else
  assign w_bad = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      COLLECT: if (w_final)   w_next = HOLD;
      HOLD:    if (w_release) w_next = COLLECT;
      default:                w_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_next;
  end

  // Output word is a separate register so it survives the shift-register clear at the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_word <= '0;
      r_len  <= '0;
      r_werr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sr  <= w_sr_next;
        r_cnt <= r_cnt + CW'(1);
        r_err <= r_err | w_bad;
      end
      if (w_final) begin
        r_word <= w_sr_next;
        r_len  <= r_cnt + CW'(1);
        r_werr <= r_err | w_bad;
      end
      if (w_release) begin
        r_sr  <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end
    end
  end

  assign bus.word       = r_word;
  assign bus.word_len   = r_len;
  assign bus.word_err   = r_werr;
  assign bus.word_valid = (r_state == HOLD);
  assign o_dbg_state    = (r_state == HOLD);
endmodule

// File: tb/tb_bcd_digit_packer.sv
// Self-checking bench for bcd_digit_packer: directed scenarios plus randomized traffic against a queue-based model.
module tb_bcd_digit_packer;
  localparam int N  = 4;
  localparam int W  = 4 * N;
  localparam int CW = $clog2(N + 1);
`ifdef BCD_DIGIT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_digit_packer_if #(.N(N)) bus ();
  logic dbg_state;

  bcd_digit_packer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_words  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Digits of the current number in arrival order; a completed number is valued as sum of digit*16^pos.
  int           m_digits[$];
  bit           m_hold  = 1'b0;
  bit           m_clean = 1'b1;
  logic [W-1:0] m_word  = '0;
  int           m_len   = 0;
  bit           m_err   = 1'b0;
  logic [W-1:0] exp_q[$];
  longint       m_acc;
  bit           m_bad;

  always @(posedge clk) begin
    if (rst) begin
      m_digits.delete();
      m_hold  = 1'b0;
      m_clean = 1'b1;
      m_word  = '0;
      m_len   = 0;
      m_err   = 1'b0;
      exp_q.delete();
    end else if (m_hold) begin
      if (bus.word_ready) m_hold = 1'b0;
    end else if (bus.din_valid) begin
      m_digits.push_back(int'(bus.din));
      if (bus.din_last || m_digits.size() == N) begin
        m_acc = 0;
        m_bad = 1'b0;
        foreach (m_digits[i]) begin
          m_acc = m_acc * 16 + m_digits[i];
          if (m_digits[i] > 9) m_bad = 1'b1;
        end
        m_word  = W'(m_acc);
        m_len   = m_digits.size();
        m_err   = CHK_EN && m_bad;
        m_hold  = 1'b1;
        m_clean = 1'b0;
        exp_q.push_back(m_word);
        m_digits.delete();
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("din_ready", 64'(bus.din_ready), 64'(!rst && !m_hold));
    chk("word_valid", 64'(bus.word_valid), 64'(m_hold));
    if (m_hold || m_clean) begin
      chk("word", 64'(bus.word), 64'(m_word));
      chk("word_len", 64'(bus.word_len), 64'(m_len));
      chk("word_err", 64'(bus.word_err), 64'(m_err));
    end
    if (!rst && bus.word_valid && bus.word_ready) begin
      n_words++;
      if (exp_q.size() == 0) fail_now("sb_unexpected_word");
      else chk("sb_word", 64'(bus.word), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input bit last);
    bit ok;
    ok = 1'b0;
    bus.din       = d;
    bus.din_valid = 1'b1;
    bus.din_last  = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.din_ready) ok = 1'b1;
      tick();
      if (ok) break;
    end
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
    if (!ok) fail_now("send_accept");
  endtask

  // Returns at a falling edge with word_valid high (or after a timeout).
  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.word_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_word_valid");
  endtask

  task automatic consume();
    tick();
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int words_before;

  initial begin
    bus.din        = 4'd0;
    bus.din_valid  = 1'b0;
    bus.din_last   = 1'b0;
    bus.word_ready = 1'b0;
    rst            = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_word", 64'(bus.word), 64'h0);
    chk("rst_word_valid", 64'(bus.word_valid), 64'h0);
    chk("rst_din_ready", 64'(bus.din_ready), 64'h0);
    tick();
    rst = 1'b0;

    // 1: full word by count, no din_last
    send(4'd1, 0); send(4'd2, 0); send(4'd1, 0); send(4'd0, 0);
    wait_valid();
    chk("t1_word", 64'(bus.word), 64'h1210);
    chk("t1_len", 64'(bus.word_len), 64'd4);
    chk("t1_err", 64'(bus.word_err), 64'd0);
    chk("t1_din_ready_hold", 64'(bus.din_ready), 64'd0);
    consume();

    // 2: short numbers terminated by din_last
    send(4'd1, 0); send(4'd2, 0); send(4'd1, 1);
    wait_valid();
    chk("t2a_word", 64'(bus.word), 64'h0121);
    chk("t2a_len", 64'(bus.word_len), 64'd3);
    consume();
    send(4'd1, 0); send(4'd2, 0); send(4'd3, 1);
    wait_valid();
    chk("t2b_word", 64'(bus.word), 64'h0123);
    chk("t2b_len", 64'(bus.word_len), 64'd3);
    consume();
    @(negedge clk);
    chk("t2_ready_after_hs", 64'(bus.din_ready), 64'd1);
    tick();

    // 3: backpressure with a pending digit 9
    send(4'd4, 0); send(4'd5, 0); send(4'd6, 0); send(4'd7, 0);
    bus.din       = 4'd9;
    bus.din_valid = 1'b1;
    bus.din_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_word_held", 64'(bus.word), 64'h4567);
      chk("t3_valid_held", 64'(bus.word_valid), 64'd1);
      chk("t3_ready_low", 64'(bus.din_ready), 64'd0);
      tick();
    end
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    tick();
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
    wait_valid();
    chk("t3_nine_word", 64'(bus.word), 64'h0009);
    chk("t3_nine_len", 64'(bus.word_len), 64'd1);
    consume();

    // 4: invalid digit code
    send(4'd1, 0); send(4'hA, 0); send(4'd0, 0); send(4'd0, 0);
    wait_valid();
    chk("t4a_word", 64'(bus.word), 64'h1A00);
    chk("t4a_err", 64'(bus.word_err), 64'(CHK_EN));
    consume();
    send(4'd0, 0); send(4'd0, 0); send(4'd1, 0); send(4'd1, 0);
    wait_valid();
    chk("t4b_word", 64'(bus.word), 64'h0011);
    chk("t4b_err", 64'(bus.word_err), 64'd0);
    consume();

    // 5: reset mid-word discards partial digits
    words_before = n_words;
    send(4'd3, 0); send(4'd3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(4'd0, 0); send(4'd0, 0); send(4'd4, 0); send(4'd4, 0);
    wait_valid();
    chk("t5_word", 64'(bus.word), 64'h0044);
    chk("t5_len", 64'(bus.word_len), 64'd4);
    consume();
    chk("t5_word_count", 64'(n_words - words_before), 64'd1);

    // 6: reset during HOLD
    send(4'd9, 0); send(4'd9, 0); send(4'd9, 0); send(4'd9, 0);
    wait_valid();
    chk("t6_held", 64'(bus.word), 64'h9999);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_cleared", 64'(bus.word_valid), 64'd0);
    chk("t6_word_cleared", 64'(bus.word), 64'd0);
    chk("t6_ready_back", 64'(bus.din_ready), 64'd1);
    tick();

    // randomized traffic, occasional resets
    for (int c = 0; c < 3000; c++) begin
      bus.din        = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      bus.din_valid  = ($urandom_range(0, 3) != 0);
      bus.din_last   = ($urandom_range(0, 3) == 0);
      bus.word_ready = ($urandom_range(0, 2) != 0);
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end
    bus.din_valid  = 1'b0;
    bus.din_last   = 1'b0;
    bus.word_ready = 1'b0;
    rst            = 1'b0;
    repeat (3) tick();
    if (n_words < 100) fail_now("random_word_throughput");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bcd_digit_packer.md
Name: bcd_digit_packer

Overview:
- Upstream feeder for the parallel divisible-by-11 checker.
- Accepts a serial stream of BCD digits, one per cycle, under a valid/ready handshake, most significant digit first.
- Packs up to N digits into a right-aligned, zero-padded 4N-bit word.
- Presents that word with valid/ready to the checker stage, holding it stable until it is consumed.

Parameters:
- N, 4, number of BCD digits per packed word; checker input width is 4*N; N >= 2.
- CW, $clog2(N+1), width of the digit-count output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  4  BCD digit
- din_valid  input  1  din holds a digit
- din_last  input  1  qualified by din_valid; digit is the final (least significant) digit of the number
- din_ready  output  1  packer accepts a digit this cycle
- word  output  4*N  packed number; digit k from the right at word[4k+3:4k]
- word_len  output  CW  number of digits received, 1..N
- word_err  output  1  at least one digit > 9 in this word (see Optional Feature)
- word_valid  output  1  word/word_len/word_err valid
- word_ready  input  1  downstream consumes word

Behaviour:
- Reset state, synchronous on the clk edge with rst=1:
  - state=COLLECT, shift register=0, cnt=0.
  - word=0, word_len=0, word_err=0, word_valid=0.
  - din_ready=0 while rst is high.
- States: COLLECT, HOLD.
- din_ready = !rst && state==COLLECT. It is driven combinationally from the registered state only, with no path from din_valid or word_ready.
- A digit is accepted on a cycle with din_valid && din_ready.
- On accept in COLLECT:
  - Shift register becomes {sr[4N-5:0], din}, so earlier digits move toward the MSB.
  - cnt increments.
  - Error flag accumulates (flag |= din > 9).
- Transition COLLECT->HOLD when the accepted digit has din_last=1, or cnt reaches N (i.e. accept with cnt==N-1). Hitting N forces completion even when din_last=0.
- Latency: word_valid rises in the cycle after the final digit is accepted. word, word_len and word_err are valid that same cycle.
- Short numbers: fewer than N digits leave zeros in the upper digit positions. Example: digits 1,2,1 with N=4 give 16'h0121.
- In HOLD:
  - word, word_len and word_err are stable and word_valid=1.
  - din_ready=0; din is ignored.
- Output handshake: on word_valid && word_ready:
  - Next cycle: word_valid=0, state=COLLECT, shift register cleared, cnt=0, error flag cleared.
  - word holds its last value until overwritten (value unspecified to the consumer when word_valid=0).
- Bubble: one cycle per word, so throughput is N+1 cycles per full word. word_ready asserted before word_valid has no effect.
- din_last on a cycle with din_valid=0 is ignored.
- Reset mid-word or during HOLD discards the partial or held word. No output is produced for the discarded digits.
- word_len uses CW bits; value N must be representable.
- Arithmetic: no carry or normalisation is done on digits. Invalid digit codes pass through into word unchanged.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined: each accepted digit is compared against 9. word_err=1 for a word containing any digit in 4'hA..4'hF; the flag clears at the output handshake and at reset.
- Undefined: no comparator is built and word_err is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
1. N=4, digits 1,2,1,0 with din_last=0, back to back -> word_valid the cycle after the 4th accept, word=16'h1210, word_len=4, word_err=0; din_ready low while in HOLD; checker d=1.
2. N=4, digits 1,2,1 with din_last on the 3rd -> word=16'h0121, word_len=3. Then digits 1,2,3 last -> word=16'h0123, d=0, with din_ready returning 1 cycle after the handshake.
3. Backpressure: complete the word 4,5,6,7 and hold word_ready=0 for 5 cycles while din_valid=1 with digit 9 -> word stays 16'h4567, word_valid=1, din_ready=0, and the digit 9 is not consumed until after the handshake.
4. With BCD_DIGIT_CHECK_EN: digits 1,A,0,0 -> word=16'h1A00, word_err=1. Next word 0,0,1,1 -> word_err=0. Without the macro, word_err=0 for both.
5. Reset mid-word: accept 3,3, then pulse rst for 1 cycle, then send 0,0,4,4 -> exactly one word, 16'h0044, word_len=4; no word containing 3,3.
6. Reset during HOLD: hold word 16'h9999, assert rst -> word_valid=0 next cycle, word=0, and din_ready=1 the first cycle after rst deasserts.
